// File: rtl/bsg_sky130_sram_pkg.sv
// rtl/bsg_sky130_sram_pkg.sv - widths and structs shared by the sky130 1rw1r SRAM arbiter
package bsg_sky130_sram_pkg;

  localparam int sram_addr_width_gp = 10;
  localparam int sram_data_width_gp = 8;
  localparam int client_id_width_gp = 4;

  typedef logic [client_id_width_gp-1:0] client_id_t;

  typedef struct packed {
    logic                          we;
    logic [sram_addr_width_gp-1:0] addr;
    logic [sram_data_width_gp-1:0] data;
  } sram_req_s;

  // A read granted last cycle: the macro presents its data this cycle
  typedef struct packed {
    logic       v;
    client_id_t id;
  } sram_tag_s;

endpackage

// File: rtl/bsg_sky130_sram_1rw1r_arb_if.sv
// rtl/bsg_sky130_sram_1rw1r_arb_if.sv - client request/response bundle of the 1rw1r arbiter
interface bsg_sky130_sram_1rw1r_arb_if
  import bsg_sky130_sram_pkg::*;
#(
  parameter int num_clients_p = 2,
  parameter int addr_width_p  = sram_addr_width_gp,
  parameter int data_width_p  = sram_data_width_gp
);

  logic [num_clients_p-1:0]              v_i;
  logic [num_clients_p-1:0]              we_i;
  logic [num_clients_p*addr_width_p-1:0] addr_i;
  logic [num_clients_p*data_width_p-1:0] data_i;
  logic [num_clients_p-1:0]              ready_o;
  logic [num_clients_p-1:0]              v_o;
  logic [num_clients_p*data_width_p-1:0] data_o;
  logic [num_clients_p-1:0]              yumi_i;

  modport master (
    output v_i, we_i, addr_i, data_i, yumi_i,
    input  ready_o, v_o, data_o
  );

  modport slave (
    input  v_i, we_i, addr_i, data_i, yumi_i,
    output ready_o, v_o, data_o
  );

endinterface

// File: rtl/bsg_sky130_sram_rr_select.sv
// rtl/bsg_sky130_sram_rr_select.sv - round-robin find-first from a pointer, with an exclude mask
module bsg_sky130_sram_rr_select #(
  parameter  int width_p      = 2,
  localparam int idx_width_lp = $clog2(width_p)
) (
  input  logic [width_p-1:0]      req_i,
  input  logic [idx_width_lp-1:0] ptr_i,
  input  logic [width_p-1:0]      exclude_i,
  output logic                    v_o,
  output logic [idx_width_lp-1:0] idx_o
);

  logic [width_p-1:0] cand;
  int                 j;

  assign cand = req_i & ~exclude_i;

  always_comb begin
    v_o   = 1'b0;
    idx_o = '0;
    j     = 0;
    for (int k = 0; k < width_p; k++) begin
      j = int'(ptr_i) + k;
      if (j >= width_p) j = j - width_p;
      if (!v_o && cand[j]) begin
        v_o   = 1'b1;
        idx_o = idx_width_lp'(j);
      end
    end
  end

endmodule

// File: rtl/bsg_sky130_sram_1rw1r_arb.sv
// rtl/bsg_sky130_sram_1rw1r_arb.sv - shares one 1rw1r sky130 SRAM macro among several clients
module bsg_sky130_sram_1rw1r_arb
  import bsg_sky130_sram_pkg::*;
#(
  parameter int num_clients_p = 2,
  parameter int addr_width_p  = sram_addr_width_gp,
  parameter int data_width_p  = sram_data_width_gp
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  bsg_sky130_sram_1rw1r_arb_if.slave cl,
  output logic                    sram_csb0_o,
  output logic                    sram_web0_o,
  output logic                    sram_wmask0_o,
  output logic [addr_width_p-1:0] sram_addr0_o,
  output logic [data_width_p-1:0] sram_din0_o,
  input  logic [data_width_p-1:0] sram_dout0_i,
  output logic                    sram_csb1_o,
  output logic [addr_width_p-1:0] sram_addr1_o,
  input  logic [data_width_p-1:0] sram_dout1_i
);

  localparam int n_lp        = num_clients_p;
  localparam int id_width_lp = $clog2(num_clients_p);

  sram_req_s                        req [n_lp];
  logic      [n_lp-1:0]             inflight, elig, ex0, ex1, grant;
  logic                             v0, v1, p0_we;
  logic      [id_width_lp-1:0]      idx0, idx1, last_idx, rr_next, rr_r;
  sram_tag_s                        tag0_r, tag1_r;
  logic      [n_lp-1:0]             v_r;
  logic      [n_lp*data_width_p-1:0] data_r;

  assign ex0 = '0;

  for (genvar i = 0; i < n_lp; i++) begin : g_client
    assign req[i] = '{we:   cl.we_i[i],
                      addr: cl.addr_i[i*addr_width_p +: addr_width_p],
                      data: cl.data_i[i*data_width_p +: data_width_p]};
    assign inflight[i] = (tag0_r.v && tag0_r.id == client_id_t'(i))
                      || (tag1_r.v && tag1_r.id == client_id_t'(i));
    // Writes never wait on the response slot; reads need a free slot by the capture edge
    assign elig[i] = reset_n_i && cl.v_i[i]
                  && (cl.we_i[i] || (!inflight[i] && (!v_r[i] || cl.yumi_i[i])));
    // Port 1 reads only, never the port0 winner, never the address port0 is writing
    assign ex1[i] = (v0 && idx0 == id_width_lp'(i)) || req[i].we
                 || (p0_we && req[i].addr == req[idx0].addr);
    assign grant[i] = (v0 && idx0 == id_width_lp'(i)) || (v1 && idx1 == id_width_lp'(i));
  end

  bsg_sky130_sram_rr_select #(.width_p(n_lp)) sel0 (
    .req_i(elig), .ptr_i(rr_r), .exclude_i(ex0), .v_o(v0), .idx_o(idx0)
  );

  bsg_sky130_sram_rr_select #(.width_p(n_lp)) sel1 (
    .req_i(elig), .ptr_i(rr_r), .exclude_i(ex1), .v_o(v1), .idx_o(idx1)
  );

  assign p0_we    = v0 && req[idx0].we;
  assign last_idx = v1 ? idx1 : idx0;
  assign rr_next  = (last_idx == id_width_lp'(n_lp-1)) ? '0 : last_idx + 1'b1;

  assign cl.ready_o    = grant;
  assign sram_csb0_o   = !v0;
  assign sram_web0_o   = !p0_we;
  assign sram_wmask0_o = p0_we;
  assign sram_addr0_o  = v0 ? req[idx0].addr : '0;
  assign sram_din0_o   = p0_we ? req[idx0].data : '0;
  assign sram_csb1_o   = !v1;
  assign sram_addr1_o  = v1 ? req[idx1].addr : '0;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rr_r   <= '0;
      tag0_r <= '0;
      tag1_r <= '0;
      v_r    <= '0;
      data_r <= '0;
    end else begin
      if (v0) rr_r <= rr_next;
      tag0_r <= '{v: v0 && !p0_we, id: client_id_t'(idx0)};
      tag1_r <= '{v: v1, id: client_id_t'(idx1)};
      // A capture landing on the yumi edge wins: the slot stays valid with the new data
      for (int i = 0; i < n_lp; i++) begin
        if (tag0_r.v && tag0_r.id == client_id_t'(i)) begin
          v_r[i]                              <= 1'b1;
          data_r[i*data_width_p +: data_width_p] <= sram_dout0_i;
        end else if (tag1_r.v && tag1_r.id == client_id_t'(i)) begin
          v_r[i]                              <= 1'b1;
          data_r[i*data_width_p +: data_width_p] <= sram_dout1_i;
        end else if (cl.yumi_i[i]) begin
          v_r[i] <= 1'b0;
        end
      end
    end
  end

  assign cl.v_o    = v_r;
  assign cl.data_o = data_r;

endmodule

// File: tb/tb_bsg_sky130_sram_1rw1r_arb.sv
// tb/tb_bsg_sky130_sram_1rw1r_arb.sv - randomized and directed bench for the 1rw1r SRAM arbiter
module tb_bsg_sky130_sram_1rw1r_arb;

  localparam int N = 3;
  localparam int A = 10;
  localparam int D = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bsg_sky130_sram_1rw1r_arb_if #(.num_clients_p(N), .addr_width_p(A), .data_width_p(D)) cl ();

  logic         csb0, web0, wmask0, csb1;
  logic [A-1:0] addr0, addr1;
  logic [D-1:0] din0, dout0, dout1;

  bsg_sky130_sram_1rw1r_arb #(.num_clients_p(N), .addr_width_p(A), .data_width_p(D)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .cl(cl),
    .sram_csb0_o(csb0), .sram_web0_o(web0), .sram_wmask0_o(wmask0),
    .sram_addr0_o(addr0), .sram_din0_o(din0), .sram_dout0_i(dout0),
    .sram_csb1_o(csb1), .sram_addr1_o(addr1), .sram_dout1_i(dout1)
  );

  // Macro stand-in: outputs are only meaningful the cycle after a read
  logic [D-1:0] mem [1024];
  always @(posedge clk) begin
    if (!csb0 && !web0 && wmask0) mem[addr0] <= din0;
    if (!csb0 && web0) dout0 <= mem[addr0];
    else               dout0 <= D'($urandom);
    if (!csb1) dout1 <= mem[addr1];
    else       dout1 <= D'($urandom);
  end

  logic [N-1:0] v, we, yumi;
  logic [A-1:0] ad [N];
  logic [D-1:0] dd [N];

  always_comb begin
    cl.addr_i = '0;
    cl.data_i = '0;
    for (int i = 0; i < N; i++) begin
      cl.addr_i[i*A +: A] = ad[i];
      cl.data_i[i*D +: D] = dd[i];
    end
  end
  assign cl.v_i    = v;
  assign cl.we_i   = we;
  assign cl.yumi_i = yumi;

  // Reference model state
  int           rr;
  logic [N-1:0] m_vo, st_v;
  logic [D-1:0] m_data [N];
  logic [D-1:0] st_d   [N];
  logic [D-1:0] m_mem  [1024];

  logic [N-1:0]   obs_ready, obs_vo;
  logic [N*D-1:0] obs_data;
  logic           obs_csb1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle();
    v    = '0;
    we   = '0;
    yumi = '0;
  endtask

  task automatic model_reset();
    rr   = 0;
    m_vo = '0;
    st_v = '0;
    for (int i = 0; i < N; i++) m_data[i] = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    v       = '1;
    we      = '0;
    yumi    = '0;
    repeat (3) begin
      @(posedge clk);
      #2;
      check("rst_ready", 32'(cl.ready_o), 32'd0);
      check("rst_csb0", 32'(csb0), 32'd1);
      check("rst_csb1", 32'(csb1), 32'd1);
      check("rst_v_o", 32'(cl.v_o), 32'd0);
    end
    check("rst_data_o", 32'(cl.data_o), 32'd0);
    model_reset();
    idle();
    reset_n = 1'b1;
  endtask

  // Inputs are already applied; predict, compare, clock, then advance the model
  task automatic step();
    logic [N-1:0] e, g;
    int w0, w1, k0, c;
    #1;
    for (int i = 0; i < N; i++)
      e[i] = v[i] && (we[i] || (!st_v[i] && (!m_vo[i] || yumi[i])));
    w0 = -1; w1 = -1; k0 = 0;
    for (int k = 0; k < N; k++) begin
      c = (rr + k) % N;
      if (w0 < 0 && e[c]) begin w0 = c; k0 = k; end
    end
    if (w0 >= 0)
      for (int k = k0 + 1; k < N; k++) begin
        c = (rr + k) % N;
        if (w1 < 0 && e[c] && !we[c] && !(we[w0] && ad[c] == ad[w0])) w1 = c;
      end
    g = '0;
    if (w0 >= 0) g[w0] = 1'b1;
    if (w1 >= 0) g[w1] = 1'b1;

    obs_ready = cl.ready_o;
    obs_vo    = cl.v_o;
    obs_data  = cl.data_o;
    obs_csb1  = csb1;
    check("ready_o", 32'(obs_ready), 32'(g));
    check("v_o", 32'(obs_vo), 32'(m_vo));
    for (int i = 0; i < N; i++)
      if (m_vo[i]) check("data_o", 32'(obs_data[i*D +: D]), 32'(m_data[i]));
    check("csb0", 32'(csb0), 32'(w0 < 0));
    check("web0", 32'(web0), 32'(!(w0 >= 0 && we[w0])));
    check("csb1", 32'(csb1), 32'(w1 < 0));
    check("rw_same_addr", 32'(!csb0 && !web0 && !csb1 && addr0 == addr1), 32'd0);

    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (st_v[i]) begin
        m_vo[i]   = 1'b1;
        m_data[i] = st_d[i];
        st_v[i]   = 1'b0;
      end else if (yumi[i]) begin
        m_vo[i] = 1'b0;
      end
    end
    if (w1 >= 0) begin st_v[w1] = 1'b1; st_d[w1] = m_mem[ad[w1]]; end
    if (w0 >= 0) begin
      if (we[w0]) m_mem[ad[w0]] = dd[w0];
      else begin st_v[w0] = 1'b1; st_d[w0] = m_mem[ad[w0]]; end
      rr = ((w1 >= 0 ? w1 : w0) + 1) % N;
    end
    #1;
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) begin mem[a] = '0; m_mem[a] = '0; end
    for (int i = 0; i < N; i++) begin ad[i] = '0; dd[i] = '0; end
    idle();
    model_reset();

    // Write then read-back through another client
    do_reset();
    v = 3'b001; we = 3'b001; ad[0] = 10'd5; dd[0] = 8'h3A; step();
    check("wr_grant", 32'(obs_ready), 32'b001);
    idle(); v = 3'b010; ad[1] = 10'd5; step();
    check("rd_grant", 32'(obs_ready), 32'b010);
    idle(); step();
    check("rd_not_yet", 32'(obs_vo[1]), 32'd0);
    step();
    check("rd_valid", 32'(obs_vo[1]), 32'd1);
    check("rd_data", 32'(obs_data[D +: D]), 32'h3A);
    step();
    check("rd_held", 32'(obs_data[D +: D]), 32'h3A);
    yumi = 3'b010; step();
    idle(); step();
    check("rd_consumed", 32'(obs_vo[1]), 32'd0);

    // Two reads in one cycle, one per port
    do_reset();
    v = 3'b001; we = 3'b001; ad[0] = 10'd1; dd[0] = 8'h11; step();
    ad[0] = 10'd2; dd[0] = 8'h22; step();
    idle(); v = 3'b011; ad[0] = 10'd1; ad[1] = 10'd2; step();
    check("dual_grant", 32'(obs_ready), 32'b011);
    idle(); step(); step();
    check("dual_valid", 32'(obs_vo), 32'b011);
    check("dual_data0", 32'(obs_data[0 +: D]), 32'h11);
    check("dual_data1", 32'(obs_data[D +: D]), 32'h22);
    yumi = 3'b011; step();
    idle(); step();

    // Same-address write and read collide: read waits a cycle
    do_reset();
    v = 3'b011; we = 3'b001; ad[0] = 10'd7; dd[0] = 8'h77; ad[1] = 10'd7; step();
    check("coll_grant", 32'(obs_ready), 32'b001);
    v = 3'b010; we = 3'b000; step();
    check("coll_retry", 32'(obs_ready), 32'b010);
    idle(); step(); step();
    check("coll_data", 32'(obs_data[D +: D]), 32'h77);
    yumi = 3'b010; step();
    idle(); step();

    // Unconsumed response blocks reads but not writes
    do_reset();
    v = 3'b001; ad[0] = 10'd5; step();
    idle(); step(); step();
    check("blk_valid", 32'(obs_vo[0]), 32'd1);
    v = 3'b001; we = 3'b000; ad[0] = 10'd9; step();
    check("blk_read0", 32'(obs_ready), 32'b000);
    step();
    check("blk_read1", 32'(obs_ready), 32'b000);
    we = 3'b001; dd[0] = 8'h99; step();
    check("blk_write", 32'(obs_ready), 32'b001);
    we = 3'b000; yumi = 3'b001; step();
    check("blk_yumi_read", 32'(obs_ready), 32'b001);
    idle(); step(); step();
    check("blk_new_data", 32'(obs_data[0 +: D]), 32'h99);
    yumi = 3'b001; step();
    idle(); step();

    // Continuous writes from all clients rotate on port 0
    do_reset();
    v = 3'b111; we = 3'b111;
    for (int i = 0; i < N; i++) begin ad[i] = 10'(20 + i); dd[i] = 8'(8'hA0 + i); end
    for (int s = 0; s < 4; s++) begin
      step();
      check("rot_grant", 32'(obs_ready), 32'(3'b001 << (s % N)));
      check("rot_csb1", 32'(obs_csb1), 32'd1);
    end
    idle();

    // Randomized traffic over a small address window, reset dropped mid-stream
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 200) do_reset();
      v    = N'($urandom);
      yumi = N'($urandom) & m_vo;
      for (int i = 0; i < N; i++) begin
        we[i] = ($urandom_range(0, 2) == 0);
        ad[i] = 10'($urandom_range(0, 7));
        dd[i] = D'($urandom);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
